// File: rtl/phy_pkg.sv
// phy_pkg: symbols and receiver state type shared across the phy link lanes
package phy_pkg;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] COMMA_SYM = 8'hBC;
  typedef enum logic [1:0] {SEARCH, LOCKING, ACTIVE} rx_state_t;
endpackage

// File: rtl/comma_detect.sv
// comma_detect: serial shift register exposing the candidate byte and a comma match
module comma_detect
  import phy_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA = COMMA_SYM
) (
  input  logic              clk_8f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] cand,
  output logic              is_comma
);
  logic [BYTE_W-1:0] shift;
  assign cand = {shift[BYTE_W-2:0], data_in};
  assign is_comma = cand == COMMA;
  always_ff @(posedge clk_8f) shift <= !reset ? '0 : cand;
endmodule

// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx: comma-aligned serial-to-byte lane receiver
// Optional RX_COMMA_COUNT_EN adds a saturating count of idle commas seen while ACTIVE.
module serial_paralelo_rx
  import phy_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA      = COMMA_SYM,
  parameter int                LOCK_COUNT = 4
) (
  input  logic              clk_8f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              active
`ifdef RX_COMMA_COUNT_EN
  ,
  output logic [15:0]       comma_count
`endif
);
  rx_state_t         state;
  logic [2:0]        bit_cnt;
  logic [3:0]        comma_cnt;
  logic [BYTE_W-1:0] cand;
  logic              is_comma;
  logic              boundary;
  comma_detect #(.COMMA(COMMA)) u_det (
    .clk_8f  (clk_8f),
    .reset   (reset),
    .data_in (data_in),
    .cand    (cand),
    .is_comma(is_comma)
  );
  assign boundary = bit_cnt == 3'd7;
  always_ff @(posedge clk_8f) begin
    if (!reset) begin
      state     <= SEARCH;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      case (state)
        SEARCH: if (is_comma) begin
          bit_cnt   <= '0;
          comma_cnt <= 4'd1;
          state     <= LOCKING;
        end
        LOCKING: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary && is_comma) begin
            comma_cnt <= comma_cnt + 4'd1;
            if (comma_cnt + 4'd1 == 4'(LOCK_COUNT)) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end
          end else if (boundary) begin
            comma_cnt <= '0;
            state     <= SEARCH;
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            valid_out <= !is_comma;
            if (!is_comma) data_out <= cand;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end
`ifdef RX_COMMA_COUNT_EN
  always_ff @(posedge clk_8f) begin
    if (!reset || state != ACTIVE) comma_count <= '0;
    else if (boundary && is_comma && comma_count != 16'hFFFF) comma_count <= comma_count + 16'd1;
  end
`endif
endmodule
